// File: rtl/tanh_pwl_stream_if.sv
// Beat-level handshake bundle for tanh_pwl_stream: input side carries samples and mode,
// output side carries results and per-lane saturation flags.
interface tanh_pwl_stream_if #(
    parameter int LANES = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
);
    logic                   s_valid;
    logic                   s_ready;
    logic [LANES*IN_W-1:0]  s_data;
    logic                   s_mode;
    logic                   m_valid;
    logic                   m_ready;
    logic [LANES*OUT_W-1:0] m_data;
    logic [LANES-1:0]       m_sat;

    modport master (
        output s_valid, s_data, s_mode, m_ready,
        input  s_ready, m_valid, m_data, m_sat
    );

    modport slave (
        input  s_valid, s_data, s_mode, m_ready,
        output s_ready, m_valid, m_data, m_sat
    );
endinterface

// File: rtl/tanh_pwl_stream.sv
// Multi-lane streaming tanh (piecewise-linear or hard-tanh) with a 3-stage elastic pipeline
// and a saturating count of output beats that hit the clamp.
module tanh_pwl_stream #(
    parameter int IN_W    = 8,
    parameter int FRAC_IN = 4,
    parameter int OUT_W   = 8,
    parameter int LANES   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    tanh_pwl_stream_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sat_count
);
    localparam int F   = FRAC_IN + 4;
    localparam int MW  = IN_W + 4;
    localparam int YW  = F + 1;
    localparam int SH  = F - (OUT_W - 1);
    localparam int SHR = (SH > 0) ? SH : 0;
    localparam int SHL = (SH < 0) ? -SH : 0;
    localparam int CW  = YW + SHL + 1;

    localparam logic [MW-1:0]    T_HALF  = MW'(1) << (F - 1);
    localparam logic [MW-1:0]    T_ONE   = MW'(1) << F;
    localparam logic [MW-1:0]    T_TWO   = MW'(2) << F;
    localparam logic [MW-1:0]    T_THREE = MW'(3) << F;
    localparam logic [MW-1:0]    C_SEG1  = MW'(1) << (F - 2);
    localparam logic [MW-1:0]    C_SEG2  = MW'(5) << (F - 3);
    localparam logic [MW-1:0]    C_SEG3  = MW'(3) << (F - 2);
    localparam logic [CW-1:0]    RND     = CW'((1 << SHR) >> 1);
    localparam logic [OUT_W-1:0] YMAX    = {1'b0, {(OUT_W-1){1'b1}}};

    typedef enum logic [2:0] {SEG_LIN, SEG_HALF, SEG_EIGHTH, SEG_SIXTEENTH, SEG_SAT} seg_e;

    // Most-negative input maps to an unsigned magnitude >= 3 and lands in SEG_SAT naturally.
    function automatic logic [MW-1:0] abs_mag(input logic signed [IN_W-1:0] x);
        logic [IN_W-1:0] a;
        a = unsigned'(x[IN_W-1] ? -x : x);
        return {a, 4'b0000};
    endfunction

    function automatic seg_e classify(input logic [MW-1:0] am, input logic hard);
        if (hard)           return (am < T_ONE) ? SEG_LIN : SEG_SAT;
        if (am < T_HALF)    return SEG_LIN;
        if (am < T_ONE)     return SEG_HALF;
        if (am < T_TWO)     return SEG_EIGHTH;
        if (am < T_THREE)   return SEG_SIXTEENTH;
        return SEG_SAT;
    endfunction

    function automatic logic [YW-1:0] pwl(input logic [MW-1:0] am, input seg_e seg);
        logic [MW-1:0] y;
        case (seg)
            SEG_LIN:       y = am;
            SEG_HALF:      y = (am >> 1) + C_SEG1;
            SEG_EIGHTH:    y = (am >> 3) + C_SEG2;
            SEG_SIXTEENTH: y = (am >> 4) + C_SEG3;
            default:       y = '0;
        endcase
        return YW'(y);
    endfunction

    // Round half-up (or widen) to OUT_W-1 fraction bits; clamp from rounding leaves m_sat alone.
    function automatic logic [OUT_W-1:0] round_clamp(input logic [YW-1:0] y, input logic sat);
        logic [CW-1:0] t;
        t = ((CW'(y) << SHL) + RND) >> SHR;
        if (sat || (t > CW'(YMAX))) return YMAX;
        return OUT_W'(t);
    endfunction

    function automatic logic signed [OUT_W-1:0] apply_sign(input logic [OUT_W-1:0] mag,
                                                           input logic neg);
        logic signed [OUT_W-1:0] m;
        m = signed'(mag);
        return neg ? -m : m;
    endfunction

    logic [LANES-1:0][IN_W-1:0]  in_lanes;
    logic                        ld_p0, ld_p1, ld_p2;
    logic                        vld_p0_q, vld_p1_q, vld_p2_q;

    logic [MW-1:0]               mag_d [LANES];
    seg_e                        seg_d [LANES];
    logic [LANES-1:0]            sgn_d;
    logic [MW-1:0]               mag_p0_q [LANES];
    seg_e                        seg_p0_q [LANES];
    logic [LANES-1:0]            sgn_p0_q;

    logic [YW-1:0]               y_d [LANES];
    logic [LANES-1:0]            sat_d;
    logic [YW-1:0]               y_p1_q [LANES];
    logic [LANES-1:0]            sat_p1_q, sgn_p1_q;

    logic [LANES-1:0][OUT_W-1:0] data_d;
    logic [LANES-1:0][OUT_W-1:0] data_p2_q;
    logic [LANES-1:0]            sat_p2_q;
    logic [CNT_W-1:0]            sat_cnt_d, sat_cnt_q;

    assign in_lanes    = bus.s_data;
    assign ld_p2       = !vld_p2_q || bus.m_ready;
    assign ld_p1       = !vld_p1_q || ld_p2;
    assign ld_p0       = !vld_p0_q || ld_p1;
    assign bus.s_ready = ld_p0;
    assign bus.m_valid = vld_p2_q;
    assign bus.m_data  = data_p2_q;
    assign bus.m_sat   = sat_p2_q;
    assign sat_count   = sat_cnt_q;

    // S1: magnitude, sign, segment
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mag_d[i] = abs_mag(in_lanes[i]);
            seg_d[i] = classify(mag_d[i], bus.s_mode);
            sgn_d[i] = in_lanes[i][IN_W-1];
        end
    end

    // S2: slope/offset
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            y_d[i]   = pwl(mag_p0_q[i], seg_p0_q[i]);
            sat_d[i] = (seg_p0_q[i] == SEG_SAT);
        end
    end

    // S3: round, clamp, sign restore
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            data_d[i] = apply_sign(round_clamp(y_p1_q[i], sat_p1_q[i]), sgn_p1_q[i]);
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (cnt_clr) begin
            sat_cnt_d = '0;
        end else if (vld_p2_q && bus.m_ready && (|sat_p2_q) && !(&sat_cnt_q)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            if (ld_p0) vld_p0_q <= bus.s_valid;
            if (ld_p1) vld_p1_q <= vld_p0_q;
            if (ld_p2) vld_p2_q <= vld_p1_q;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_p0 && bus.s_valid) begin
            mag_p0_q <= mag_d;
            seg_p0_q <= seg_d;
            sgn_p0_q <= sgn_d;
        end
        if (ld_p1 && vld_p0_q) begin
            y_p1_q   <= y_d;
            sat_p1_q <= sat_d;
            sgn_p1_q <= sgn_p0_q;
        end
    end

    // Output registers are visible on the bus, so they come out of reset cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p2_q <= '0;
            sat_p2_q  <= '0;
        end else if (ld_p2 && vld_p1_q) begin
            data_p2_q <= data_d;
            sat_p2_q  <= sat_p1_q;
        end
    end
endmodule
